// File: rtl/dc_ipu_shr_pipeline_arbiter.sv
// Packet-locked round-robin arbiter sharing one IPU pipeline input.
// Grant holds from first beat to last beat; output is a registered stage.
module dc_ipu_shr_pipeline_arbiter #(
  parameter int N      = 4,
  parameter int DATA_W = 24,
  localparam int IW    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  clr,
  input  logic [N-1:0]          req_valid,
  input  logic [N-1:0]          req_last,
  input  logic [N*DATA_W-1:0]   req_data,
  output logic [N-1:0]          req_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [IW-1:0]         grant_idx,
  output logic                  busy
);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t      state;
  logic [IW-1:0] ptr;

  logic [IW-1:0] win;
  logic          found;
  int            cand;

  // First requester after the pointer, wrapping N-1 -> 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req_valid[IW'(cand)]) begin
        win   = IW'(cand);
        found = 1'b1;
      end
    end
  end

  logic              take_ok;
  logic              accept;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [N-1:0]      one_hot;

  assign take_ok  = !out_valid || out_ready;
  assign one_hot  = {{(N-1){1'b0}}, 1'b1} << grant_idx;
  assign req_ready = (state == LOCK && take_ok) ? one_hot : '0;
  assign accept   = (state == LOCK) && take_ok && req_valid[grant_idx];
  assign sel_last = req_last[grant_idx];
  assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      ptr       <= IW'(N-1);
      grant_idx <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      state     <= IDLE;
      ptr       <= IW'(N-1);
      grant_idx <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_idx <= win;
            state     <= LOCK;
            busy      <= 1'b1;
          end
        end
        LOCK: begin
          if (accept && sel_last) begin
            ptr   <= grant_idx;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // Output stage: load on accept, drain on downstream take.
      if (accept) begin
        out_valid <= 1'b1;
        out_last  <= sel_last;
        out_data  <= sel_data;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dc_ipu_shr_pipeline_arbiter.sv
// Bench for the packet-locked arbiter: cycle model plus
// literal grant-order and payload expectations.
module tb_dc_ipu_shr_pipeline_arbiter;
  localparam int N = 4;
  localparam int W = 24;

  logic           clk = 1'b0;
  logic           nreset;
  logic           clr;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_last;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [1:0]     grant_idx;
  logic           busy;

  dc_ipu_shr_pipeline_arbiter #(.N(N), .DATA_W(W)) dut (
    .clk(clk), .nreset(nreset), .clr(clr),
    .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_last(out_last),
    .out_data(out_data), .out_ready(out_ready),
    .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [W:0]   q [N][$];
  logic [N-1:0] hold;
  int           glog[$];
  logic [W-1:0] got[$];
  logic [W-1:0] expd[$];

  // Model: packet owner (-1 when free), round-robin pointer, output beat.
  int           m_owner;
  int           m_ptr;
  int           m_gidx;
  logic         m_ov;
  logic         m_ol;
  logic [W-1:0] m_od;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = N-1; m_gidx = 0;
    m_ov = 0; m_ol = 0; m_od = '0;
  endtask

  task automatic model_update();
    int g;
    if (!nreset || clr) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        g = (m_ptr + k) % N;
        if (req_valid[g]) begin
          m_owner = g;
          m_gidx  = g;
          glog.push_back(g);
          break;
        end
      end
      if (m_ov && out_ready) m_ov = 0;
    end else begin
      g = m_owner;
      if (req_valid[g] && (!m_ov || out_ready)) begin
        m_ov = 1;
        m_od = q[g][0][W-1:0];
        m_ol = q[g][0][W];
        void'(q[g].pop_front());
        if (m_ol) begin
          m_ptr   = g;
          m_owner = -1;
        end
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i] = !hold[i];
        req_last[i]  = q[i][0][W];
        req_data[i*W +: W] = q[i][0][W-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'($urandom_range(0, 1));
        req_data[i*W +: W] = W'($urandom);
      end
    end
  endtask

  task automatic run(input int n);
    drive();
    repeat (n) begin
      @(posedge clk);
      model_update();
      #1;
      drive();
    end
  endtask

  function automatic logic [W-1:0] beat(input int p, input int b);
    return W'(32'hA00000 + (p << 8) + b);
  endfunction

  task automatic pkt(input int p, input int len);
    for (int b = 0; b < len; b++)
      q[p].push_back({b == len-1, beat(p, b)});
  endtask

  task automatic exp_pkt(input int p, input int len);
    for (int b = 0; b < len; b++) expd.push_back(beat(p, b));
  endtask

  task automatic check_out(input string nm);
    chk({nm, ".beats"}, got.size(), expd.size());
    for (int i = 0; i < got.size() && i < expd.size(); i++)
      chk({nm, ".data"}, got[i], expd[i]);
    for (int i = 0; i < N; i++) chk({nm, ".drain"}, q[i].size(), 0);
    got.delete();
    expd.delete();
  endtask

  task automatic check_glog(input string nm, input int n,
                            input int e0, input int e1,
                            input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({nm, ".grants"}, glog.size(), n);
    for (int i = 0; i < n && i < glog.size(); i++)
      chk({nm, ".order"}, glog[i], e[i]);
    glog.delete();
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] er;
    er = '0;
    if (m_owner >= 0 && (!m_ov || out_ready)) er[m_owner] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("out_valid", out_valid, m_ov);
    chk("out_last", out_last, m_ol);
    chk("out_data", out_data, m_od);
    chk("grant_idx", grant_idx, m_gidx);
    chk("busy", busy, m_owner >= 0);
    if (nreset && out_valid && out_ready) got.push_back(out_data);
  end

  initial begin
    nreset = 1'b0; clr = 1'b0; out_ready = 1'b1; hold = '0;
    req_valid = '0; req_last = '0; req_data = '0;
    model_reset();
    run(3);
    nreset = 1'b1;

    // Idle after reset
    run(10);
    @(negedge clk);
    chk("idle.out_valid", out_valid, 0);
    chk("idle.busy", busy, 0);
    chk("idle.req_ready", req_ready, 0);

    // Four packets, round-robin 0..3
    for (int p = 0; p < N; p++) pkt(p, 4);
    run(2);
    @(negedge clk);
    chk("rr.first_valid", out_valid, 1);
    chk("rr.first_data", out_data, 24'hA00000);
    run(25);
    check_glog("rr", 4, 0, 1, 2, 3);
    for (int p = 0; p < N; p++) exp_pkt(p, 4);
    check_out("rr");

    // Lock: port 0 arrives while port 2 is mid-packet
    pkt(2, 8);
    run(3);
    pkt(0, 2);
    run(20);
    check_glog("lock", 2, 2, 0, 0, 0);
    exp_pkt(2, 8);
    exp_pkt(0, 2);
    check_out("lock");

    // Downstream stall and a source gap
    pkt(1, 6);
    run(3);
    out_ready = 1'b0;
    run(3);
    out_ready = 1'b1;
    hold[1] = 1'b1;
    run(2);
    hold[1] = 1'b0;
    run(12);
    check_glog("stall", 1, 1, 0, 0, 0);
    exp_pkt(1, 6);
    check_out("stall");

    // Wrap-around after port 3
    pkt(3, 2);
    run(10);
    pkt(0, 3);
    pkt(3, 2);
    run(20);
    check_glog("wrap", 3, 3, 0, 3, 0);
    exp_pkt(3, 2);
    exp_pkt(0, 3);
    exp_pkt(3, 2);
    check_out("wrap");

    // Clear mid-packet
    pkt(2, 5);
    run(2);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    q[2].delete();
    got.delete();
    drive();
    @(negedge clk);
    chk("clr.out_valid", out_valid, 0);
    chk("clr.busy", busy, 0);
    chk("clr.grant_idx", grant_idx, 0);
    pkt(1, 2);
    pkt(0, 2);
    run(15);
    check_glog("clr", 3, 2, 0, 1, 0);
    exp_pkt(0, 2);
    exp_pkt(1, 2);
    check_out("clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
